// File: rtl/msk_pipe_en.sv
// Elastic pipeline for masked sharings: depth stages of share-preserving mux+register with valid/ready flow.
// Optional MSKPIPE_FLUSH_CLEAR_EN: a flush also zeroes every data register so no stale shares survive.
module msk_pipe_en #(
  parameter int d     = 2,
  parameter int count = 1,
  parameter int depth = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [count*d-1:0]             in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [count*d-1:0]             out,
  output logic [$clog2(depth+1)-1:0]     level
);

  localparam int W  = count * d;
  localparam int LW = $clog2(depth + 1);

  logic [depth-1:0] v_q, v_d;
  logic [depth-1:0] adv, take;
  logic [W-1:0]     data_q [depth];
  logic [W-1:0]     data_d [depth];

  // Handshake chain: a stage advances when its successor is empty or advancing itself.
  // NOTE: blocking assignments are correct here; the chain is evaluated last stage first within one pass.
  always_comb begin
    adv      = '0;
    take     = '0;
    v_d      = '0;
    in_ready = 1'b0;
    adv[depth-1] = v_q[depth-1] & out_ready;
    for (int i = depth - 2; i >= 0; i--) begin
      adv[i] = v_q[i] & (~v_q[i+1] | adv[i+1]);
    end
    in_ready = ~rst & ~flush & (~v_q[0] | adv[0]);
    take[0]  = in_valid & in_ready;
    for (int i = 1; i < depth; i++) begin
      take[i] = adv[i-1] & ~flush;
    end
    for (int i = 0; i < depth; i++) begin
      v_d[i] = ~flush & (take[i] | (v_q[i] & ~adv[i]));
    end
  end

  // Each share bit is selected independently; shares are never combined.
  always_comb begin
    data_d[0] = take[0] ? in : data_q[0];
    for (int i = 1; i < depth; i++) begin
      data_d[i] = take[i] ? data_q[i-1] : data_q[i];
    end
`ifdef MSKPIPE_FLUSH_CLEAR_EN
    if (flush) begin
      for (int i = 0; i < depth; i++) begin
        data_d[i] = '0;
      end
    end
`endif
  end

  // NOTE: the data registers are reset too, so out reads 0 under reset and no shares leak across it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < depth; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

  assign out       = data_q[depth-1];
  assign out_valid = v_q[depth-1] & ~flush;
  assign level     = LW'($countones(v_q));

endmodule

// File: doc/msk_pipe_en.md
MSK_PIPE_EN -- requirements
Module: msk_pipe_en

Interface
REQ-001 SHALL have parameter d, default 2: number of shares per masked bit.
REQ-002 SHALL have parameter count, default 1: number of masked bits per sharing bus.
REQ-003 SHALL have parameter depth, default 3, legal range 1..16: number of register stages.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port flush, input, 1 bit: control input; drops all in-flight words.
REQ-007 SHALL have port in_valid, input, 1 bit: upstream word present.
REQ-008 SHALL have port in_ready, output, 1 bit: pipeline accepts the word this cycle.
REQ-009 SHALL have port in, input, count*d bits: input sharing, with the same share layout as the codebase's masked register cells.
REQ-010 SHALL have port out_valid, output, 1 bit: output stage holds a word.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream consumes the word this cycle.
REQ-012 SHALL have port out, output, count*d bits: output sharing, driven directly by the last stage's data register.
REQ-013 SHALL have port level, output, clog2(depth+1) bits: number of occupied stages.

Function
REQ-014 SHALL implement depth stages, each with one valid flag v[i] and one count*d data register; stage 0 is the input and stage depth-1 is the output.
REQ-015 SHALL define advance of the last stage as v[depth-1] & out_ready, and SHALL define advance[i] for i<depth-1 as v[i] & (!v[i+1] | advance[i+1]).
REQ-016 SHALL drive in_ready = !flush & (!v[0] | advance[0]), computed combinationally and allowing full throughput with one word per cycle.
REQ-017 SHALL load a stage data register only when its stage takes a new word; otherwise it SHALL hold its value, using the masked-mux-plus-register structure with no logic combining different shares.
REQ-018 SHALL give a latency of exactly depth cycles from accept (in_valid & in_ready) to out_valid when no stall occurs.
REQ-019 SHALL drive out_valid = v[depth-1] & !flush, and SHALL leave out constant while out_valid=1 and out_ready=0.
REQ-020 SHALL, when all stages are full and out_ready=0, deassert in_ready and lose no word.
REQ-021 SHALL, when all stages are full and out_ready=1, accept a new word in the same cycle as the output word leaves.
REQ-022 SHALL update level to the count of set v[i] each cycle, with a range of 0..depth that never wraps.
REQ-023 SHALL, when flush=1 (synchronous), clear all v[i] at the next edge, treat the input in that cycle as not accepted, and treat the output in that cycle as not transferred.
REQ-024 SHALL give flush priority over in_valid and out_ready arriving in the same cycle.
REQ-025 SHALL keep word order first-in first-out, with no duplication and no reordering.

Reset
REQ-026 SHALL, while rst=1, immediately clear all v[i] and all data registers to 0.
REQ-027 SHALL drive out_valid=0, in_ready=0, level=0 and out=0 while rst=1.
REQ-028 SHALL discard all in-flight words on a reset asserted mid-operation.
REQ-029 SHALL allow the first accept on the first rising edge after rst deasserts.

Configuration
REQ-030 SHALL provide macro MSKPIPE_FLUSH_CLEAR_EN to control flush-clear of the data registers.
REQ-031 SHALL, when MSKPIPE_FLUSH_CLEAR_EN is defined, load all data registers with 0 at the flush edge as well as clearing the valid flags, so that no stale shares are retained.
REQ-032 SHALL, when MSKPIPE_FLUSH_CLEAR_EN is undefined, have flush clear only the valid flags while the data registers hold their prior contents, which gives lower area.

Verification
REQ-033 SHALL cover the stream case: with d=2, count=4, depth=3 and out_ready=1, present words 0x11, 0x22, 0x33 on consecutive cycles; out SHALL show 0x11, 0x22, 0x33 on cycles 3, 4, 5, with out_valid high exactly for those 3 cycles.
REQ-034 SHALL cover the stall case: hold out_ready=0 and offer 4 words; in_ready SHALL drop after the 3rd accept, level SHALL read 3, and after out_ready=1 the words SHALL appear in order with none lost.
REQ-035 SHALL cover full pass-through: with the pipeline full and in_valid=1, out_ready=1, one word SHALL enter and one SHALL leave per cycle, and level SHALL stay at 3.
REQ-036 SHALL cover flush: with level=2, assert flush with in_valid=1 for one cycle; the next cycle SHALL show level=0 and out_valid=0, and the word offered during flush SHALL never appear; with MSKPIPE_FLUSH_CLEAR_EN, all data registers SHALL read 0.
REQ-037 SHALL cover reset mid-operation: assert rst asynchronously between edges with level=3; out_valid, level and out SHALL go to 0 immediately, and after release a new word 0xAB SHALL emerge 3 cycles after its accept.
REQ-038 SHALL cover the depth=1 case: the single stage SHALL give a latency of 1 cycle, and in_ready SHALL equal !v[0] | out_ready.
